// File: rtl/npu_pkg.sv
// Shared NPU types: controller instruction slot width, opcode/instruction layout and
// the instruction-queue unpacker state encoding.
package npu_pkg;

  localparam int unsigned SLOT_WIDTH = 256;

  typedef enum logic [3:0] {
    OP_NOP    = 4'd0,
    OP_LOAD   = 4'd1,
    OP_STORE  = 4'd2,
    OP_MATMUL = 4'd3,
    OP_ACT    = 4'd4,
    OP_SYNC   = 4'd5
  } operation_t;

  typedef struct packed {
    operation_t              op;
    logic [SLOT_WIDTH-5:0]   payload;
  } instruction_t;

  typedef enum logic {
    U_IDLE  = 1'b0,
    U_DRAIN = 1'b1
  } unpack_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read port, occupancy count and a
// synchronous flush that has priority over reads and writes.
module sync_fifo #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty,
  output logic             o_full
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_wr;
  logic             w_do_rd;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  // A full FIFO refuses the write even when a pop frees a slot in the same cycle.
  assign w_do_wr = i_wr_en && !o_full && !i_flush;
  assign w_do_rd = i_rd_en && !o_empty && !i_flush;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) begin
        r_mem[r_wr_ptr] <= i_wr_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(w_do_wr) - CNT_W'(w_do_rd);
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_count   = r_count;

endmodule

// File: rtl/inst_queue.sv
// Instruction front-end: unpacks multi-slot host words into a FWFT FIFO for the controller.
// Optional performance counters are built when INST_QUEUE_PERF_EN is defined.
module inst_queue
  import npu_pkg::*;
#(
  parameter int unsigned INST_WIDTH = 512,
  parameter int unsigned DEPTH      = 16,
  localparam int unsigned SLOTS     = INST_WIDTH / SLOT_WIDTH,
  localparam int unsigned CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  inst_in_valid,
  input  logic [INST_WIDTH-1:0] inst_in_data,
  input  logic [SLOTS-1:0]      inst_in_mask,
  output logic                  inst_in_ready,
  output logic [SLOT_WIDTH-1:0] instruction,
  output logic                  instruction_valid,
  input  logic                  instruction_ready,
  output logic [CNT_WIDTH-1:0]  q_count,
  output logic                  q_empty,
  output logic                  q_full
`ifdef INST_QUEUE_PERF_EN
  ,
  output logic [31:0]           perf_issued,
  output logic [31:0]           perf_stall
`endif
);

  localparam int unsigned IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  unpack_state_e          r_state;
  logic [INST_WIDTH-1:0]  r_hold_data;
  logic [SLOTS-1:0]       r_hold_mask;

  logic                   w_found;
  logic [IDX_W-1:0]       w_slot_idx;
  logic [SLOTS-1:0]       w_mask_rest;
  logic [SLOT_WIDTH-1:0]  w_slot_data;
  logic                   w_slot_wr;
  logic                   w_last_slot;
  logic                   w_in_hs;
  logic                   w_pop;

  // Pick the lowest still-pending slot of the held word.
  always_comb begin
    w_found     = 1'b0;
    w_slot_idx  = '0;
    w_slot_data = '0;
    for (int k = 0; k < int'(SLOTS); k++) begin
      if (!w_found && r_hold_mask[k]) begin
        w_found     = 1'b1;
        w_slot_idx  = IDX_W'(k);
        w_slot_data = r_hold_data[k*SLOT_WIDTH +: SLOT_WIDTH];
      end
    end
    w_mask_rest             = r_hold_mask;
    w_mask_rest[w_slot_idx] = 1'b0;
  end

  assign w_slot_wr   = (r_state == U_DRAIN) && !q_full && !flush;
  assign w_last_slot = w_slot_wr && (w_mask_rest == '0);
  // Ready rises in the cycle the last slot drains so words stream back-to-back.
  assign inst_in_ready = !flush && ((r_state == U_IDLE) || w_last_slot);
  assign w_in_hs       = inst_in_valid && inst_in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= U_IDLE;
      r_hold_data <= '0;
      r_hold_mask <= '0;
    end else if (flush) begin
      r_state     <= U_IDLE;
      r_hold_data <= '0;
      r_hold_mask <= '0;
    end else begin
      if (w_slot_wr) r_hold_mask <= w_mask_rest;
      if (w_last_slot) r_state <= U_IDLE;
      if (w_in_hs) begin
        r_hold_data <= inst_in_data;
        r_hold_mask <= inst_in_mask;
        r_state     <= (inst_in_mask != '0) ? U_DRAIN : U_IDLE;
      end
    end
  end

  assign instruction_valid = !q_empty;
  assign w_pop             = instruction_valid && instruction_ready && !flush;

  sync_fifo #(
    .WIDTH (SLOT_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk     (clk),
    .i_rst     (reset),
    .i_flush   (flush),
    .i_wr_en   (w_slot_wr),
    .i_wr_data (w_slot_data),
    .i_rd_en   (w_pop),
    .o_rd_data (instruction),
    .o_count   (q_count),
    .o_empty   (q_empty),
    .o_full    (q_full)
  );

`ifdef INST_QUEUE_PERF_EN
  logic [31:0] r_perf_issued;
  logic [31:0] r_perf_stall;

  // Saturating counters; flush deliberately leaves them alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_issued <= '0;
      r_perf_stall  <= '0;
    end else begin
      if (w_pop && (r_perf_issued != '1)) r_perf_issued <= r_perf_issued + 1'b1;
      if (instruction_valid && !instruction_ready && (r_perf_stall != '1)) begin
        r_perf_stall <= r_perf_stall + 1'b1;
      end
    end
  end

  assign perf_issued = r_perf_issued;
  assign perf_stall  = r_perf_stall;
`endif

endmodule
